// File: rtl/prog_loader_pkg.sv
// Shared constants for the program loader: FSM state encodings and the default frame marker.
package prog_loader_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_LEN_H = 3'd1;
   localparam logic [2:0] ST_LEN_L = 3'd2;
   localparam logic [2:0] ST_DATA  = 3'd3;
   localparam logic [2:0] ST_CSUM  = 3'd4;
   localparam logic [2:0] ST_DONE  = 3'd5;
   localparam logic [2:0] ST_ERR   = 3'd6;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

endpackage

// File: rtl/prog_loader.sv
// Framed byte-stream loader: writes a payload into program memory from address 0 and
// holds the CPU halted until a frame with a valid checksum has been written completely.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int         addr_width     = 8,
   parameter int         data_width     = 8,
   parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
   parameter int         TIMEOUT_CYCLES = 1000000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [7:0]            in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [addr_width-1:0] prog_addr,
   output logic [data_width-1:0] prog_din,
   output logic                  prog_we,
   output logic                  cpu_hold,
   output logic                  load_done,
   output logic                  load_err,
   output logic [2:0]            dbg_state
);

   // Handshake: a byte transfers on a rising edge where in_valid and in_ready are both 1;
   // the source must keep in_data stable while in_valid is high and in_ready is low.

   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [31:0] MAX_LEN = (32'd1 << addr_width) - 32'd1;

   logic [2:0]            state_q, state_d;
   logic [15:0]           rem_q, rem_d;
   logic [addr_width-1:0] ptr_q, ptr_d;
   logic [7:0]            sum_q, sum_d;
   logic [7:0]            len_hi_q, len_hi_d;
   logic [TW-1:0]         tmo_q, tmo_d;
   logic                  hold_q, hold_d;
   logic [addr_width-1:0] addr_q, addr_d;
   logic [data_width-1:0] din_q, din_d;
   logic                  we_q, we_d;
   logic                  rdy_en_q;

   logic                  accept;
   logic [7:0]            sum_add;
   logic [15:0]           len_w;

   assign in_ready  = rdy_en_q && (state_q != ST_DONE) && (state_q != ST_ERR);
   assign accept    = in_valid && in_ready;
   assign sum_add   = sum_q + in_data;
   assign len_w     = {len_hi_q, in_data};

   assign prog_addr = addr_q;
   assign prog_din  = din_q;
   assign prog_we   = we_q;
   assign cpu_hold  = hold_q;
   assign load_done = (state_q == ST_DONE);
   assign load_err  = (state_q == ST_ERR);
   assign dbg_state = state_q;

   always_comb begin
      state_d  = state_q;
      rem_d    = rem_q;
      ptr_d    = ptr_q;
      sum_d    = sum_q;
      len_hi_d = len_hi_q;
      tmo_d    = '0;
      hold_d   = hold_q;
      addr_d   = addr_q;
      din_d    = din_q;
      we_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (accept && (in_data == SYNC_BYTE)) begin
               state_d = ST_LEN_H;
               hold_d  = 1'b1;
            end
         end
         ST_LEN_H: begin
            if (accept) begin
               len_hi_d = in_data;
               sum_d    = in_data;
               state_d  = ST_LEN_L;
            end
         end
         ST_LEN_L: begin
            if (accept) begin
               sum_d = sum_add;
               // Oversize frames are rejected here, so ptr can never wrap during DATA.
               if (32'(len_w) > MAX_LEN) begin
                  state_d = ST_ERR;
               end else begin
                  rem_d   = len_w;
                  ptr_d   = '0;
                  state_d = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (accept) begin
               we_d   = 1'b1;
               addr_d = ptr_q;
               din_d  = data_width'(in_data);
               ptr_d  = ptr_q + 1'b1;
               sum_d  = sum_add;
               if (rem_q == 16'd0) state_d = ST_CSUM;
               else                rem_d   = rem_q - 16'd1;
            end
         end
         ST_CSUM: begin
            if (accept) state_d = (sum_add == 8'h00) ? ST_DONE : ST_ERR;
         end
         ST_DONE: begin
            hold_d  = 1'b0;
            state_d = ST_IDLE;
         end
         ST_ERR: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Inter-byte watchdog, active only while a frame is open.
      if (state_q inside {ST_LEN_H, ST_LEN_L, ST_DATA, ST_CSUM} && !accept) begin
         if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) state_d = ST_ERR;
         else                                  tmo_d   = tmo_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         rem_q    <= '0;
         ptr_q    <= '0;
         sum_q    <= '0;
         len_hi_q <= '0;
         tmo_q    <= '0;
         hold_q   <= 1'b0;
         addr_q   <= '0;
         din_q    <= '0;
         we_q     <= 1'b0;
         rdy_en_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         rem_q    <= rem_d;
         ptr_q    <= ptr_d;
         sum_q    <= sum_d;
         len_hi_q <= len_hi_d;
         tmo_q    <= tmo_d;
         hold_q   <= hold_d;
         addr_q   <= addr_d;
         din_q    <= din_d;
         we_q     <= we_d;
         rdy_en_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: frames are built from a queue-based model of the frame format and
// every memory write is checked against an expected queue of (cycle, address, data).
module tb_prog_loader;
   import prog_loader_pkg::*;

   localparam int         AW    = 4;
   localparam int         DEPTH = 1 << AW;
   localparam int         TMO   = 8;
   localparam logic [7:0] SYNC  = 8'hA5;

   logic          clk;
   logic          rst_n;
   logic [7:0]    in_data;
   logic          in_valid;
   logic          in_ready;
   logic [AW-1:0] prog_addr;
   logic [7:0]    prog_din;
   logic          prog_we;
   logic          cpu_hold;
   logic          load_done;
   logic          load_err;
   logic [2:0]    dbg_state;

   int checks;
   int errors;
   int ncnt;
   int done_cnt;
   int err_cnt;
   logic [55:0] exp_q[$];
   logic [7:0]  pl_q[$];

   prog_loader #(
      .addr_width    (AW),
      .data_width    (8),
      .SYNC_BYTE     (SYNC),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .prog_addr(prog_addr),
      .prog_din (prog_din),
      .prog_we  (prog_we),
      .cpu_hold (cpu_hold),
      .load_done(load_done),
      .load_err (load_err),
      .dbg_state(dbg_state)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1);
   end

   // write scoreboard and pulse counters, sampled on the falling edge
   initial begin
      logic [55:0] e;
      logic [55:0] got;
      ncnt = 0;
      done_cnt = 0;
      err_cnt = 0;
      forever begin
         @(negedge clk);
         ncnt++;
         if (load_done === 1'b1) done_cnt++;
         if (load_err === 1'b1) err_cnt++;
         if (prog_we === 1'b1) begin
            checks++;
            got = {32'(ncnt), 16'(prog_addr), prog_din};
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write cycle=%0d addr=%0h din=%0h", ncnt, prog_addr, prog_din);
            end else begin
               e = exp_q.pop_front();
               if (got !== e)
                  begin
                     errors++;
                     $display("FAIL write cycle/addr/din got=%0d/%0h/%0h exp=%0d/%0h/%0h",
                              got[55:24], got[23:8], got[7:0], e[55:24], e[23:8], e[7:0]);
                  end
            end
         end
      end
   end

   // driver tasks
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         #1;
         in_valid = 1'b0;
         in_data  = 8'($urandom);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit payload, input int addr);
      bit acc;
      acc = 1'b0;
      for (int i = 0; i < 8 && !acc; i++) begin
         @(negedge clk);
         #1;
         in_valid = 1'b1;
         in_data  = b;
         acc = in_ready;
         if (acc && payload) exp_q.push_back({32'(ncnt + 1), 16'(addr), b});
         @(posedge clk);
      end
      checks++;
      if (!acc) begin
         errors++;
         $display("FAIL byte_accept byte=%0h in_ready stayed 0 exp=1", b);
      end
   endtask

   task automatic fill_payload(input int n);
      pl_q.delete();
      for (int k = 0; k < n; k++) pl_q.push_back(8'($urandom));
   endtask

   // Frame model: SYNC, (N-1) big-endian, payload, then a byte making the sum of
   // everything after SYNC equal zero mod 256; 'bad' is added to that byte.
   task automatic send_frame(input int n, input int gap, input logic [7:0] bad);
      logic [15:0] f;
      logic [7:0]  s;
      f = 16'(n - 1);
      send_byte(SYNC, 1'b0, 0);
      idle(gap);
      send_byte(f[15:8], 1'b0, 0);
      idle(gap);
      send_byte(f[7:0], 1'b0, 0);
      s = f[15:8] + f[7:0];
      if (n > DEPTH) return;
      for (int k = 0; k < n; k++) begin
         idle(gap);
         send_byte(pl_q[k], 1'b1, k);
         s = s + pl_q[k];
      end
      idle(gap);
      send_byte(8'(8'h00 - s) + bad, 1'b0, 0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid = 1'b0;
      in_data = 8'h00;
      repeat (3) @(negedge clk);
      checks++;
      if ({in_ready, prog_we, cpu_hold, load_done, load_err} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl got=%b exp=00000", {in_ready, prog_we, cpu_hold, load_done, load_err});
      end
      checks++;
      if ({prog_addr, prog_din} !== '0) begin
         errors++;
         $display("FAIL reset_addr_din got=%0h/%0h exp=0/0", prog_addr, prog_din);
      end
      #1 rst_n = 1'b1;
      idle(2);
      checks++;
      if (in_ready !== 1'b1 || cpu_hold !== 1'b0) begin
         errors++;
         $display("FAIL after_reset in_ready/cpu_hold got=%b/%b exp=1/0", in_ready, cpu_hold);
      end
   endtask

   task automatic test_good_frame();
      int d0, e0;
      d0 = done_cnt; e0 = err_cnt;
      pl_q = '{8'h11, 8'h22, 8'h33, 8'h44};
      send_frame(4, 0, 8'h00);
      idle(20);
      checks++;
      if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin
         errors++;
         $display("FAIL good_frame done/err pulses got=%0d/%0d exp=1/0", done_cnt - d0, err_cnt - e0);
      end
      checks++;
      if (cpu_hold !== 1'b0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL good_frame cpu_hold/pending got=%b/%0d exp=0/0", cpu_hold, exp_q.size());
      end
   endtask

   task automatic test_bad_csum();
      int d0, e0;
      d0 = done_cnt; e0 = err_cnt;
      pl_q = '{8'h11, 8'h22, 8'h33, 8'h44};
      send_frame(4, 0, 8'h01);
      idle(20);
      checks++;
      if (done_cnt - d0 !== 0 || err_cnt - e0 !== 1) begin
         errors++;
         $display("FAIL bad_csum done/err pulses got=%0d/%0d exp=0/1", done_cnt - d0, err_cnt - e0);
      end
      checks++;
      if (cpu_hold !== 1'b1 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL bad_csum cpu_hold/pending got=%b/%0d exp=1/0", cpu_hold, exp_q.size());
      end
      fill_payload(5);
      send_frame(5, 0, 8'h00);
      idle(20);
      checks++;
      if (cpu_hold !== 1'b0 || done_cnt - d0 !== 1) begin
         errors++;
         $display("FAIL recover cpu_hold/done got=%b/%0d exp=0/1", cpu_hold, done_cnt - d0);
      end
   endtask

   task automatic test_length_bounds();
      int d0, e0;
      d0 = done_cnt; e0 = err_cnt;
      fill_payload(17);
      send_frame(17, 0, 8'h00);
      idle(20);
      checks++;
      if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0 || cpu_hold !== 1'b1) begin
         errors++;
         $display("FAIL oversize err/done/hold got=%0d/%0d/%b exp=1/0/1", err_cnt - e0, done_cnt - d0, cpu_hold);
      end
      fill_payload(DEPTH);
      send_frame(DEPTH, 0, 8'h00);
      idle(20);
      checks++;
      if (done_cnt - d0 !== 1 || err_cnt - e0 !== 1 || cpu_hold !== 1'b0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL full_depth done/err/hold/pending got=%0d/%0d/%b/%0d exp=1/1/0/0",
                  done_cnt - d0, err_cnt - e0, cpu_hold, exp_q.size());
      end
   endtask

   task automatic test_noise_gaps();
      int d0;
      d0 = done_cnt;
      send_byte(8'h00, 1'b0, 0);
      send_byte(8'hFF, 1'b0, 0);
      send_byte(8'h5A, 1'b0, 0);
      idle(2);
      checks++;
      if (cpu_hold !== 1'b0 || dbg_state !== ST_IDLE) begin
         errors++;
         $display("FAIL noise cpu_hold/state got=%b/%0d exp=0/%0d", cpu_hold, dbg_state, ST_IDLE);
      end
      pl_q = '{8'h11, SYNC, 8'h33, 8'h44};
      send_frame(4, 3, 8'h00);
      idle(20);
      checks++;
      if (done_cnt - d0 !== 1 || cpu_hold !== 1'b0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL gapped done/hold/pending got=%0d/%b/%0d exp=1/0/0", done_cnt - d0, cpu_hold, exp_q.size());
      end
   endtask

   task automatic test_timeout();
      int e0;
      e0 = err_cnt;
      send_byte(SYNC, 1'b0, 0);
      send_byte(8'h00, 1'b0, 0);
      send_byte(8'h03, 1'b0, 0);
      send_byte(8'h21, 1'b1, 0);
      send_byte(8'h43, 1'b1, 1);
      idle(TMO - 2);
      checks++;
      if (cpu_hold !== 1'b1 || err_cnt - e0 !== 0) begin
         errors++;
         $display("FAIL pre_timeout hold/err got=%b/%0d exp=1/0", cpu_hold, err_cnt - e0);
      end
      idle(3 * TMO);
      checks++;
      if (err_cnt - e0 !== 1 || dbg_state !== ST_IDLE || cpu_hold !== 1'b1 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL timeout err/state/hold/pending got=%0d/%0d/%b/%0d exp=1/%0d/1/0",
                  err_cnt - e0, dbg_state, cpu_hold, exp_q.size(), ST_IDLE);
      end
   endtask

   task automatic test_reset_mid_frame();
      int d0;
      fill_payload(2);
      send_byte(SYNC, 1'b0, 0);
      send_byte(8'h00, 1'b0, 0);
      send_byte(8'h05, 1'b0, 0);
      send_byte(pl_q[0], 1'b1, 0);
      send_byte(pl_q[1], 1'b1, 1);
      idle(2);
      rst_n = 1'b0;
      #2;
      checks++;
      if ({cpu_hold, prog_we, load_done, load_err, in_ready} !== 5'b0) begin
         errors++;
         $display("FAIL mid_reset hold/we/done/err/rdy got=%b exp=00000",
                  {cpu_hold, prog_we, load_done, load_err, in_ready});
      end
      idle(2);
      rst_n = 1'b1;
      idle(5);
      checks++;
      if (cpu_hold !== 1'b0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL post_reset hold/pending got=%b/%0d exp=0/0", cpu_hold, exp_q.size());
      end
      d0 = done_cnt;
      fill_payload(6);
      send_frame(6, 0, 8'h00);
      idle(20);
      checks++;
      if (done_cnt - d0 !== 1 || cpu_hold !== 1'b0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL reload done/hold/pending got=%0d/%b/%0d exp=1/0/0", done_cnt - d0, cpu_hold, exp_q.size());
      end
   endtask

   task automatic test_random_frames();
      int d0, e0, n, gap;
      bit ok;
      logic [7:0] bad;
      for (int t = 0; t < 10; t++) begin
         d0 = done_cnt; e0 = err_cnt;
         n   = $urandom_range(1, DEPTH + 2);
         gap = $urandom_range(0, 2);
         bad = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
         ok  = (n <= DEPTH) && (bad == 8'h00);
         fill_payload(n);
         send_frame(n, gap, bad);
         idle(20);
         checks++;
         if (done_cnt - d0 !== int'(ok) || err_cnt - e0 !== int'(!ok) || cpu_hold !== !ok || exp_q.size() != 0) begin
            errors++;
            $display("FAIL random[%0d] n=%0d done/err/hold/pending got=%0d/%0d/%b/%0d exp=%0d/%0d/%b/0",
                     t, n, done_cnt - d0, err_cnt - e0, cpu_hold, exp_q.size(), ok, !ok, !ok);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_good_frame();
      test_bad_csum();
      test_length_bounds();
      test_noise_gaps();
      test_timeout();
      test_reset_mid_frame();
      test_random_frames();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
